// File: rtl/riscv_mem_pkg.sv
// Shared types for the fetch/data SRAM arbiter: FSM states, response owner
// and the full-word byte-enable constant.
package riscv_mem_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/riscv_be_merge.sv
// Combinational 4-lane byte merge: lanes with be set take the new word,
// the rest keep the old word.
module riscv_be_merge (
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  input  logic [3:0]  i_be,
  output logic [31:0] o_word
);

  always_comb begin
    o_word = i_old;
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) o_word[8*i +: 8] = i_new[8*i +: 8];
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates one synchronous-read word SRAM between instruction fetch and
// data access; partial stores are sequenced as read-modify-write.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AW         = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic [31:0]   dm_addr,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [31:0]   dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [31:0]   dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output state_t        o_dbg_state
);

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  // Handshake: a request is held stable until its gnt is seen high in the
  // same cycle; rvalid follows exactly one cycle after the access completes.
  state_t        r_state, w_state_nxt;
  owner_t        r_owner, w_owner_nxt;
  logic          r_dm_rd, w_dm_rd_nxt;
  logic [3:0]    r_starve, w_starve_nxt;
  logic [AW-1:0] r_rmw_addr;
  logic [3:0]    r_rmw_be;
  logic [31:0]   r_rmw_wdata;
  logic          w_rmw_start;
  logic          w_if_win, w_dm_win;
  logic [AW-1:0] w_if_waddr, w_dm_waddr;
  logic [31:0]   w_merged;
  logic          w_unused;

  assign w_if_waddr = if_addr[AW+1:2];
  assign w_dm_waddr = dm_addr[AW+1:2];
  assign w_unused   = ^{if_addr[31:AW+2], if_addr[1:0], dm_addr[31:AW+2], dm_addr[1:0]};

  riscv_be_merge u_merge (
    .i_old  (mem_rdata),
    .i_new  (r_rmw_wdata),
    .i_be   (r_rmw_be),
    .o_word (w_merged)
  );

  always_comb begin
    w_if_win     = 1'b0;
    w_dm_win     = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    w_state_nxt  = r_state;
    w_owner_nxt  = OWN_NONE;
    w_dm_rd_nxt  = 1'b0;
    w_rmw_start  = 1'b0;
    w_starve_nxt = r_starve;
    // Grants are suppressed while reset is asserted.
    if (rstn && r_state == ST_IDLE) begin
      w_if_win = if_req && (r_starve == LP_STARVE_MAX || !dm_req);
      w_dm_win = dm_req && !w_if_win;
    end
    case (r_state)
      ST_IDLE: begin
        if (!if_req || w_if_win)                      w_starve_nxt = 4'd0;
        else if (w_dm_win && r_starve != LP_STARVE_MAX) w_starve_nxt = r_starve + 4'd1;
        if (w_if_win) begin
          mem_en      = 1'b1;
          mem_addr    = w_if_waddr;
          w_owner_nxt = OWN_IF;
        end else if (w_dm_win) begin
          mem_addr    = w_dm_waddr;
          w_owner_nxt = OWN_DM;
          if (!dm_we) begin
            mem_en      = 1'b1;
            w_dm_rd_nxt = 1'b1;
          end else if (dm_be == BE_FULL) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = dm_wdata;
          end else if (dm_be != 4'h0) begin
            mem_en      = 1'b1;
            w_rmw_start = 1'b1;
            w_owner_nxt = OWN_NONE;
            w_state_nxt = ST_RMW_WR;
          end
        end
      end
      ST_RMW_WR: begin
        mem_en      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = r_rmw_addr;
        mem_wdata   = w_merged;
        w_owner_nxt = OWN_DM;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_NONE;
      r_dm_rd     <= 1'b0;
      r_starve    <= 4'd0;
      r_rmw_addr  <= '0;
      r_rmw_be    <= 4'h0;
      r_rmw_wdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_dm_rd  <= w_dm_rd_nxt;
      r_starve <= w_starve_nxt;
      if (w_rmw_start) begin
        r_rmw_addr  <= w_dm_waddr;
        r_rmw_be    <= dm_be;
        r_rmw_wdata <= dm_wdata;
      end
    end
  end

  assign if_gnt      = w_if_win;
  assign dm_gnt      = w_dm_win;
  assign if_rvalid   = (r_owner == OWN_IF);
  assign if_rdata    = mem_rdata;
  assign dm_rvalid   = (r_owner == OWN_DM);
  assign dm_rdata    = (dm_rvalid && r_dm_rd) ? mem_rdata : 32'h0;
  assign o_dbg_state = r_state;

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Shares one single-port, synchronous-read word SRAM between the RV32I core's instruction-fetch requester and data requester. Arbitrates per cycle with data priority and a starvation guard for fetch. Sequences byte and halfword stores as a read-modify-write, because the SRAM only supports full-word writes. Sits between the core's fetch/LSU request ports and the SRAM macro.

## Interface
- `AW`, 14: SRAM word-address width (SRAM holds 2^AW words).
- `STARVE_MAX`, 4: consecutive data grants allowed while fetch is waiting (range 1..15).
- `clk` in 1: clock; all state changes on the rising edge.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `if_req` in 1: fetch request; held until granted.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: `if_rdata` valid.
- `if_rdata` out 32: fetched word.
- `dm_req` in 1: data request; held stable until granted.
- `dm_addr` in 32: data byte address.
- `dm_we` in 1: 1 = store.
- `dm_be` in 4: byte enables, already lane-aligned.
- `dm_wdata` in 32: store data, already lane-aligned.
- `dm_gnt` out 1: data request accepted this cycle.
- `dm_rvalid` out 1: completion; carries load data for reads.
- `dm_rdata` out 32: load word; 0 for stores.
- `mem_en` out 1: SRAM access this cycle.
- `mem_we` out 1: SRAM write (full word).
- `mem_addr` out AW: SRAM word address.
- `mem_wdata` out 32: SRAM write data.
- `mem_rdata` in 32: SRAM read data, valid the cycle after a read access.

## Operation
- **Address mapping:** word address = `addr[AW+1:2]`. Bits [1:0] and bits above AW+1 are ignored.
- **States:**
  - IDLE: may grant.
  - RMW_WR: write half of a read-modify-write; no grant.
- **Arbitration (IDLE only):**
  - Data wins if `dm_req`.
  - Exception: fetch wins when `if_req` and `starve_cnt == STARVE_MAX`.
  - Exactly one grant per cycle at most. Grants are combinational on the requests and the state.
- **Fetch grant:** read SRAM this cycle; `if_rvalid` is asserted the next cycle with `if_rdata = mem_rdata`.
- **Data read grant:** read SRAM; `dm_rvalid` and `dm_rdata = mem_rdata` the next cycle. `dm_be` is ignored.
- **Data write, `dm_be == 4'hF`:** single-cycle write of `dm_wdata`; `dm_rvalid` the next cycle.
- **Data write, `dm_be == 4'h0`:** no SRAM access; `dm_rvalid` the next cycle.
- **Data write, other `dm_be`:**
  - Grant cycle: read SRAM and latch addr/be/wdata; go to RMW_WR.
  - RMW_WR: write the merge, per byte `be[i] ? wdata : mem_rdata`; go to IDLE.
  - `dm_rvalid` is asserted in the cycle after RMW_WR.
- **`starve_cnt`:**
  - +1 on each data grant while `if_req` is high, saturating at STARVE_MAX.
  - Cleared on fetch grant or when `if_req` is low.
  - Holds during RMW_WR.
- Back-to-back reads: one grant per cycle; the rvalid stream is one cycle delayed and in order.

## Timing
- Reset values: state = IDLE, `starve_cnt` = 0, both rvalid = 0, latched RMW fields = 0. Consequently all grants and `mem_en` are 0 while `rstn` is low.
- Read latency: 1 cycle from grant to rvalid.
- Write latency:
  - Full-word store: 1 cycle to `dm_rvalid`.
  - Partial store: 2 cycles to `dm_rvalid`; the port is busy 2 cycles.
- During RMW_WR: `if_gnt = dm_gnt = 0` even with requests pending. The RMW write takes precedence over everything.
- `if_rdata` and `dm_rdata` are valid only when the matching rvalid is high. Otherwise `dm_rdata` = 0, and `if_rdata` is don't-care.
- Reset mid-RMW: the write is dropped, no rvalid is issued, and the SRAM word is left unchanged (the read half is harmless).
- Simultaneous `if_req` and `dm_req` with `starve_cnt < STARVE_MAX`: data granted, fetch stalled.

## Structure
- Package `riscv_mem_pkg` holds:
  - the state enum (IDLE, RMW_WR);
  - the owner enum (NONE, IF, DM), used for the registered response select;
  - constant `BE_FULL = 4'hF`.
- One natural sub-module: `riscv_be_merge`, a combinational 4-lane byte merge of old word, new word and be. Everything else stays in the top.

## Test plan
- **Fetch read:** `if_req`, `if_addr=0x10`, SRAM[4]=0xDEADBEEF → `if_gnt` in cycle 0; `if_rvalid` with `if_rdata=0xDEADBEEF` in cycle 1.
- **Byte store RMW:** SRAM[2]=0x11223344; store `addr=0x9`, `be=4'b0010`, `wdata=0x0000AA00` → read in cycle 0, write 0x1122AA44 in cycle 1, `dm_rvalid` in cycle 2; no grant in cycle 1.
- **Starvation guard:** `if_req` and `dm_req` held high continuously, `STARVE_MAX=4` → grant sequence D,D,D,D,I,D,D,D,D,I.
- **Enable edge cases:** store `be=0` → no `mem_en`, `dm_rvalid` next cycle. Store `be=F`, `wdata=0xCAFEF00D` → single write cycle, word reads back 0xCAFEF00D.
- **Reset mid-RMW:** partial store granted; `rstn` low in RMW_WR → no `mem_we`, no rvalid, state IDLE, target word unchanged.
- **Back-to-back data reads:** addresses 0x0, 0x4, 0x8 in consecutive cycles → three grants, then three `dm_rvalid` in order with the matching words.
